icache_direct: RTL and testbench

- Direct-mapped, read-only instruction cache; one per core.
- Sits between the core fetch stage and the shared memory controller.
- Serves fetch hits combinationally from on-chip frames. On a miss, issues a single-word instruction read on the iREN/iaddr/iwait/iload channel and fills the frame.
- Keeps saturating hit/miss counters for performance reporting.

---
 rtl/icache_direct.sv | 143 ++++++++++++++
 tb/tb_icache_direct.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, read-only instruction cache for one core.
// Fetch hits are answered combinationally from register-based frames. A miss
// latches the word address and moves to FETCH, which holds a single-word read
// on the iREN/iaddr channel until iwait drops, then fills the frame.
// Saturating hit/miss counters are kept for performance reporting.
//
// Ports:
//   CLK, RST             clock, synchronous active-high reset
//   imemREN, imemaddr    fetch request and byte address from the core
//   ihit, imemload       hit flag and instruction word back to the core
//   iREN, iaddr          read request / word address to the memory controller
//   iwait, iload         controller busy flag and returned data
//   flush                invalidate all frames
//   hit_count,miss_count saturating performance counters
//
// state | meaning
// IDLE  | serving lookups; a miss latches its address and moves to FETCH
// FETCH | read outstanding to memory; fill frame when iwait drops
module icache_direct #(
  parameter int SETS  = 16,
  parameter int IDX_W = $clog2(SETS),
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             imemREN,
  input  logic [31:0]      imemaddr,
  output logic             ihit,
  output logic [31:0]      imemload,
  output logic             iREN,
  output logic [31:0]      iaddr,
  input  logic             iwait,
  input  logic [31:0]      iload,
  input  logic             flush,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic [0:0] {IDLE = 1'b0, FETCH = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [SETS-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [TAG_W-1:0]  tag_d  [SETS];
  logic [31:0]       data_q [SETS];
  logic [31:0]       data_d [SETS];
  logic [29:0]       miss_addr_q, miss_addr_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  fill_idx;
  logic [TAG_W-1:0]  fill_tag;
  logic              lookup_hit;
  logic              lookup_miss;
  logic              unused_offset;

  assign req_idx       = imemaddr[IDX_W+1:2];
  assign req_tag       = imemaddr[31:IDX_W+2];
  assign fill_idx      = miss_addr_q[IDX_W-1:0];
  assign fill_tag      = miss_addr_q[29:IDX_W];
  assign unused_offset = ^imemaddr[1:0];

  // Lookups only count in IDLE; during FETCH the core sees no hit at all.
  assign lookup_hit  = imemREN && (state_q == IDLE) && valid_q[req_idx] &&
                       (tag_q[req_idx] == req_tag);
  assign lookup_miss = imemREN && (state_q == IDLE) && !lookup_hit;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      miss_addr_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      miss_addr_q <= miss_addr_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  // Tag and data contents need no reset; valid bits gate them.
  always_ff @(posedge CLK) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (lookup_miss) state_d = FETCH;
      FETCH:   if (!iwait)      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame, miss address and counter updates
  always_comb begin
    valid_d     = valid_q;
    tag_d       = tag_q;
    data_d      = data_q;
    miss_addr_d = miss_addr_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;

    // Flush is applied before the fill so an in-flight fill still lands valid.
    if (flush) valid_d = '0;

    if (lookup_hit && (hit_cnt_q != {CNT_W{1'b1}}))
      hit_cnt_d = hit_cnt_q + CNT_W'(1);

    if (lookup_miss) begin
      miss_addr_d = imemaddr[31:2];
      if (miss_cnt_q != {CNT_W{1'b1}})
        miss_cnt_d = miss_cnt_q + CNT_W'(1);
    end

    if ((state_q == FETCH) && !iwait) begin
      valid_d[fill_idx] = 1'b1;
      tag_d[fill_idx]   = fill_tag;
      data_d[fill_idx]  = iload;
    end
  end

  // Output logic
  always_comb begin
    ihit       = lookup_hit;
    imemload   = lookup_hit ? data_q[req_idx] : 32'h0;
    iREN       = (state_q == FETCH);
    iaddr      = (state_q == FETCH) ? {miss_addr_q, 2'b00} : 32'h0;
    hit_count  = hit_cnt_q;
    miss_count = miss_cnt_q;
  end

endmodule

// File: tb/tb_icache_direct.sv
module tb_icache_direct;

  // Narrow counters keep the saturation runs short.
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          CLK, RST;
  logic          imemREN, iwait, flush;
  logic [31:0]   imemaddr, iload;
  logic          ihit, iREN;
  logic [31:0]   imemload, iaddr;
  logic [CW-1:0] hit_count, miss_count;

  int n_cmp = 0;
  int n_bad = 0;

  icache_direct #(.SETS(16), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload),
    .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload),
    .flush(flush),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        iw;
    logic [31:0] ild;
    logic        fl;
    logic        e_hit;
    logic [31:0] e_load;
    logic        e_ren;
    logic [31:0] e_iaddr;
    int          e_hc;
    int          e_mc;
  } vec_t;

  vec_t vt [19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Inputs change just after the falling edge; outputs are checked 1ns later,
  // well before the next rising edge.
  task automatic drive(input logic req, input logic [31:0] addr, input logic iw,
                       input logic [31:0] ild, input logic fl);
    @(negedge CLK);
    imemREN  = req;
    imemaddr = addr;
    iwait    = iw;
    iload    = ild;
    flush    = fl;
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; imemREN = 1'b0; imemaddr = '0; iwait = 1'b1; iload = '0; flush = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1; imemREN = 1'b0; imemaddr = '0; iwait = 1'b1; iload = '0; flush = 1'b0;

    //        req addr         iw  iload        fl hit load         ren iaddr       hc mc
    vt[0]  = '{1, 32'h40, 1, 32'h0,        0, 0, 32'h0,        0, 32'h0,  0, 0};
    vt[1]  = '{0, 32'h0,  0, 32'h20010005, 0, 0, 32'h0,        1, 32'h40, 0, 1};
    vt[2]  = '{1, 32'h40, 1, 32'h0,        0, 1, 32'h20010005, 0, 32'h0,  0, 1};
    vt[3]  = '{0, 32'h40, 1, 32'h0,        0, 0, 32'h0,        0, 32'h0,  1, 1};
    vt[4]  = '{1, 32'h80, 1, 32'h0,        0, 0, 32'h0,        0, 32'h0,  1, 1};
    vt[5]  = '{0, 32'h0,  0, 32'hBBBB0002, 0, 0, 32'h0,        1, 32'h80, 1, 2};
    vt[6]  = '{1, 32'h80, 1, 32'h0,        0, 1, 32'hBBBB0002, 0, 32'h0,  1, 2};
    vt[7]  = '{1, 32'h40, 1, 32'h0,        0, 0, 32'h0,        0, 32'h0,  2, 2};
    vt[8]  = '{0, 32'h0,  0, 32'hAAAA0001, 0, 0, 32'h0,        1, 32'h40, 2, 3};
    vt[9]  = '{1, 32'h40, 1, 32'h0,        0, 1, 32'hAAAA0001, 0, 32'h0,  2, 3};
    vt[10] = '{1, 32'h44, 1, 32'h0,        0, 0, 32'h0,        0, 32'h0,  3, 3};
    vt[11] = '{1, 32'h40, 0, 32'h11112222, 0, 0, 32'h0,        1, 32'h44, 3, 4};
    vt[12] = '{1, 32'h47, 1, 32'h0,        0, 1, 32'h11112222, 0, 32'h0,  3, 4};
    vt[13] = '{1, 32'h40, 1, 32'h0,        1, 1, 32'hAAAA0001, 0, 32'h0,  4, 4};
    vt[14] = '{1, 32'h44, 1, 32'h0,        0, 0, 32'h0,        0, 32'h0,  5, 4};
    vt[15] = '{1, 32'h44, 1, 32'h0,        0, 0, 32'h0,        1, 32'h44, 5, 5};
    vt[16] = '{1, 32'h44, 0, 32'h33334444, 0, 0, 32'h0,        1, 32'h44, 5, 5};
    vt[17] = '{1, 32'h44, 1, 32'h0,        0, 1, 32'h33334444, 0, 32'h0,  5, 5};
    vt[18] = '{1, 32'h40, 1, 32'h0,        0, 0, 32'h0,        0, 32'h0,  6, 5};

    do_reset();
    #1;
    chk("rst_ihit", 32'(ihit), 32'd0);
    chk("rst_iren", 32'(iREN), 32'd0);
    chk("rst_iaddr", iaddr, 32'h0);
    chk("rst_imemload", imemload, 32'h0);
    chk("rst_hit_count", 32'(hit_count), 32'd0);
    chk("rst_miss_count", 32'(miss_count), 32'd0);

    for (int i = 0; i < 19; i++) begin
      drive(vt[i].req, vt[i].addr, vt[i].iw, vt[i].ild, vt[i].fl);
      chk($sformatf("v%0d_ihit", i), 32'(ihit), 32'(vt[i].e_hit));
      chk($sformatf("v%0d_imemload", i), imemload, vt[i].e_load);
      chk($sformatf("v%0d_iren", i), 32'(iREN), 32'(vt[i].e_ren));
      chk($sformatf("v%0d_iaddr", i), iaddr, vt[i].e_iaddr);
      chk($sformatf("v%0d_hit_count", i), 32'(hit_count), 32'(vt[i].e_hc));
      chk($sformatf("v%0d_miss_count", i), 32'(miss_count), 32'(vt[i].e_mc));
    end

    // Long iwait: request stays asserted, address stays stable.
    do_reset();
    drive(1, 32'h0C, 1, 32'h0, 0);
    chk("wait_first_ihit", 32'(ihit), 32'd0);
    for (int k = 0; k < 5; k++) begin
      drive(1, 32'h0C, 1, 32'hDEAD0000, 0);
      chk($sformatf("wait%0d_iren", k), 32'(iREN), 32'd1);
      chk($sformatf("wait%0d_iaddr", k), iaddr, 32'h0C);
      chk($sformatf("wait%0d_ihit", k), 32'(ihit), 32'd0);
    end
    drive(1, 32'h0C, 0, 32'hCAFE0C0C, 0);
    chk("wait_done_iren", 32'(iREN), 32'd1);
    chk("wait_done_ihit", 32'(ihit), 32'd0);
    drive(1, 32'h0C, 1, 32'h0, 0);
    chk("wait_after_ihit", 32'(ihit), 32'd1);
    chk("wait_after_load", imemload, 32'hCAFE0C0C);
    chk("wait_after_iren", 32'(iREN), 32'd0);

    // Branch redirect during a fill: the latched address still gets filled.
    do_reset();
    drive(1, 32'h100, 1, 32'h0, 0);
    drive(0, 32'h200, 0, 32'h01000100, 0);
    chk("redir_iaddr", iaddr, 32'h100);
    drive(0, 32'h200, 1, 32'h0, 0);
    chk("redir_idle_iren", 32'(iREN), 32'd0);
    drive(1, 32'h100, 1, 32'h0, 0);
    chk("redir_hit", 32'(ihit), 32'd1);
    chk("redir_load", imemload, 32'h01000100);
    chk("redir_no_iren", 32'(iREN), 32'd0);

    // Reset while fetching abandons the fill even if data returns at that edge.
    do_reset();
    drive(1, 32'h140, 1, 32'h0, 0);
    drive(0, 32'h0, 1, 32'h0, 0);
    chk("rstf_iren_before", 32'(iREN), 32'd1);
    @(negedge CLK);
    RST = 1'b1; iwait = 1'b0; iload = 32'h14014014; flush = 1'b1;
    @(negedge CLK);
    RST = 1'b0; iwait = 1'b1; flush = 1'b0; imemREN = 1'b0;
    #1;
    chk("rstf_iren_after", 32'(iREN), 32'd0);
    chk("rstf_hit_count", 32'(hit_count), 32'd0);
    chk("rstf_miss_count", 32'(miss_count), 32'd0);
    drive(1, 32'h140, 1, 32'h0, 0);
    chk("rstf_refetch_miss", 32'(ihit), 32'd0);
    drive(0, 32'h0, 1, 32'h0, 0);
    chk("rstf_refetch_iren", 32'(iREN), 32'd1);

    // Flush during FETCH: other frames invalidated, in-flight fill survives.
    do_reset();
    drive(1, 32'h40, 1, 32'h0, 0);
    drive(0, 32'h0, 0, 32'hD1D1D1D1, 0);
    drive(1, 32'h44, 1, 32'h0, 0);
    chk("ffl_miss44", 32'(ihit), 32'd0);
    drive(0, 32'h0, 0, 32'hD2D2D2D2, 1);
    chk("ffl_iaddr", iaddr, 32'h44);
    drive(1, 32'h44, 1, 32'h0, 0);
    chk("ffl_fill_survives", 32'(ihit), 32'd1);
    chk("ffl_fill_data", imemload, 32'hD2D2D2D2);
    drive(1, 32'h40, 1, 32'h0, 0);
    chk("ffl_other_flushed", 32'(ihit), 32'd0);

    // Counter saturation: distinct tags at index 0 all miss.
    do_reset();
    for (int k = 0; k < CMAX + 2; k++) begin
      drive(1, 32'(k) << 6, 1, 32'h0, 0);
      drive(0, 32'h0, 0, 32'(k), 0);
      if (k == CMAX - 1) begin
        drive(0, 32'h0, 1, 32'h0, 0);
        chk("sat_miss_at_max", 32'(miss_count), 32'(CMAX));
      end
    end
    drive(0, 32'h0, 1, 32'h0, 0);
    chk("sat_miss_hold", 32'(miss_count), 32'(CMAX));
    for (int k = 0; k < CMAX + 2; k++) begin
      drive(1, 32'(CMAX + 1) << 6, 1, 32'h0, 0);
    end
    chk("sat_last_hit_data", imemload, 32'(CMAX + 1));
    drive(0, 32'h0, 1, 32'h0, 0);
    chk("sat_hit_hold", 32'(hit_count), 32'(CMAX));
    chk("sat_miss_still", 32'(miss_count), 32'(CMAX));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
